// File: rtl/wb_write_buffer32_pkg.sv
// Shared widths, FIFO entry layout and master FSM
// encodings for the posted-write buffer.
package wb_write_buffer32_pkg;

  localparam int ADR_W = 32;
  localparam int SEL_W = 4;
  localparam int DAT_W = 32;
  localparam int ENT_W = ADR_W + SEL_W + DAT_W;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat;
  } wb_ent_t;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } mstate_e;

endpackage

// File: rtl/wb_write_buffer32_fifo.sv
// Synchronous circular FIFO holding posted writes.
// Storage has no reset so it maps onto LUT RAM.
module wb_wbuf_fifo
  import wb_write_buffer32_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wb_ent_t                  din_i,
  output wb_ent_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(depth):0]   count_o
);

  localparam int AW = $clog2(depth);
  localparam logic [AW-1:0] P_ONE = 1;
  localparam logic [AW:0]   C_ONE = 1;
  localparam logic [AW:0]   C_FULL = (AW+1)'(depth);

  wb_ent_t       mem_q [depth];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == C_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + P_ONE;
    if (do_pop)  rptr_d = rptr_q + P_ONE;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + C_ONE;
      2'b01:   cnt_d = cnt_q - C_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_write_buffer32.sv
// Posted-write buffer: acks core writes at once, drains
// them in order, and holds reads until the queue is empty.
module wb_write_buffer32
  import wb_write_buffer32_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_stb_i,
  input  logic             s_cyc_i,
  input  logic             s_we_i,
  input  logic [ADR_W-1:0] s_adr_i,
  input  logic [SEL_W-1:0] s_sel_i,
  input  logic [DAT_W-1:0] s_dat_i,
  output logic             s_ack_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic             m_stb_o,
  output logic             m_cyc_o,
  output logic             m_we_o,
  output logic [ADR_W-1:0] m_adr_o,
  output logic [SEL_W-1:0] m_sel_o,
  output logic [DAT_W-1:0] m_dat_o,
  input  logic             m_ack_i,
  input  logic [DAT_W-1:0] m_dat_i
);

  localparam int AW = $clog2(depth);

  mstate_e          state_q, state_d;
  logic             s_ack_q, s_ack_d;
  logic [DAT_W-1:0] s_dat_q, s_dat_d;
  logic             m_stb_q, m_stb_d;
  logic             m_we_q, m_we_d;
  logic [ADR_W-1:0] m_adr_q, m_adr_d;
  logic [SEL_W-1:0] m_sel_q, m_sel_d;
  logic [DAT_W-1:0] m_dat_q, m_dat_d;

  logic    s_wr, s_rd, push, pop;
  logic    full, empty;
  logic [AW:0] count;
  wb_ent_t head, din;

  // The ack term keeps one request from being taken twice.
  assign s_wr = s_stb_i & s_cyc_i & s_we_i & ~s_ack_q;
  assign s_rd = s_stb_i & s_cyc_i & ~s_we_i & ~s_ack_q;
  assign push = s_wr & ~full;
  assign din  = '{adr: s_adr_i, sel: s_sel_i, dat: s_dat_i};

  wb_wbuf_fifo #(
    .depth(depth)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (din),
    .head_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  always_comb begin
    state_d = state_q;
    s_ack_d = push;
    s_dat_d = s_dat_q;
    m_stb_d = m_stb_q;
    m_we_d  = m_we_q;
    m_adr_d = m_adr_q;
    m_sel_d = m_sel_q;
    m_dat_d = m_dat_q;
    pop     = 1'b0;
    unique case (state_q)
      M_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          m_adr_d = head.adr;
          m_sel_d = head.sel;
          m_dat_d = head.dat;
          m_stb_d = 1'b1;
          m_we_d  = 1'b1;
          state_d = M_WRITE;
        end else if (s_rd && count == '0) begin
          m_adr_d = s_adr_i;
          m_sel_d = s_sel_i;
          m_stb_d = 1'b1;
          m_we_d  = 1'b0;
          state_d = M_READ;
        end else begin
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
        end
      end
      M_WRITE: begin
        if (m_ack_i) begin
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = M_IDLE;
        end
      end
      M_READ: begin
        if (m_ack_i) begin
          m_stb_d = 1'b0;
          s_dat_d = m_dat_i;
          s_ack_d = 1'b1;
          state_d = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= M_IDLE;
      s_ack_q <= 1'b0;
      s_dat_q <= '0;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_sel_q <= '0;
      m_dat_q <= '0;
    end else begin
      state_q <= state_d;
      s_ack_q <= s_ack_d;
      s_dat_q <= s_dat_d;
      m_stb_q <= m_stb_d;
      m_we_q  <= m_we_d;
      m_adr_q <= m_adr_d;
      m_sel_q <= m_sel_d;
      m_dat_q <= m_dat_d;
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign m_stb_o = m_stb_q;
  assign m_cyc_o = m_stb_q;
  assign m_we_o  = m_we_q;
  assign m_adr_o = m_adr_q;
  assign m_sel_o = m_sel_q;
  assign m_dat_o = m_dat_q;

endmodule

// File: tb/tb_wb_write_buffer32.sv
// Directed bench for the posted-write buffer.
// Inputs change and outputs are sampled on the falling edge.
module tb_wb_write_buffer32;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_stb_i, s_cyc_i, s_we_i;
  logic [31:0] s_adr_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_dat_i;
  logic        s_ack_o;
  logic [31:0] s_dat_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [31:0] m_adr_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_o;
  logic        m_ack_i;
  logic [31:0] m_dat_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_write_buffer32 #(.depth(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_stb_i(s_stb_i),
    .s_cyc_i(s_cyc_i),
    .s_we_i (s_we_i),
    .s_adr_i(s_adr_i),
    .s_sel_i(s_sel_i),
    .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o),
    .s_dat_o(s_dat_o),
    .m_stb_o(m_stb_o),
    .m_cyc_o(m_cyc_o),
    .m_we_o (m_we_o),
    .m_adr_o(m_adr_o),
    .m_sel_o(m_sel_o),
    .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i),
    .m_dat_i(m_dat_i)
  );

  task automatic idle_bus();
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
    s_we_i  = 1'b0;
  endtask

  task automatic drive_wr(input logic [31:0] a,
                          input logic [3:0] s,
                          input logic [31:0] d);
    s_stb_i = 1'b1;
    s_cyc_i = 1'b1;
    s_we_i  = 1'b1;
    s_adr_i = a;
    s_sel_i = s;
    s_dat_i = d;
  endtask

  task automatic drive_rd(input logic [31:0] a,
                          input logic [3:0] s);
    s_stb_i = 1'b1;
    s_cyc_i = 1'b1;
    s_we_i  = 1'b0;
    s_adr_i = a;
    s_sel_i = s;
  endtask

  task automatic wait_sack(output int n);
    n = 0;
    while (!s_ack_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!s_ack_o) n = -1;
  endtask

  task automatic wait_mstb(output int n);
    n = 0;
    while (!m_stb_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!m_stb_o) n = -1;
  endtask

  task automatic mack_pulse();
    m_ack_i = 1'b1;
    @(negedge clk);
    m_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    m_ack_i = 1'b0;
    m_dat_i = '0;
    s_adr_i = '0;
    s_sel_i = '0;
    s_dat_i = '0;
    idle_bus();
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({s_ack_o, s_dat_o} !== 33'd0)
      $display("FAIL rst_slave: got %h exp 0",
               {s_ack_o, s_dat_o});
    else pass_cnt++;
    total_cnt++;
    if ({m_stb_o, m_cyc_o, m_we_o} !== 3'b000)
      $display("FAIL rst_ctl: got %b exp 000",
               {m_stb_o, m_cyc_o, m_we_o});
    else pass_cnt++;
    total_cnt++;
    if ({m_adr_o, m_sel_o, m_dat_o} !== 68'd0)
      $display("FAIL rst_bus: got %h exp 0",
               {m_adr_o, m_sel_o, m_dat_o});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({s_ack_o, m_stb_o} !== 2'b00)
      $display("FAIL rst_release: got %b exp 00",
               {s_ack_o, m_stb_o});
    else pass_cnt++;
  endtask

  task automatic test_single_write();
    drive_wr(32'h100, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    total_cnt++;
    if ({s_ack_o, m_stb_o} !== 2'b10)
      $display("FAIL wr_ack: got %b exp 10",
               {s_ack_o, m_stb_o});
    else pass_cnt++;
    idle_bus();
    @(negedge clk);
    total_cnt++;
    if ({s_ack_o, m_stb_o, m_cyc_o, m_we_o} !== 4'b0111)
      $display("FAIL wr_mctl: got %b exp 0111",
               {s_ack_o, m_stb_o, m_cyc_o, m_we_o});
    else pass_cnt++;
    total_cnt++;
    if ({m_adr_o, m_sel_o, m_dat_o} !==
        {32'h100, 4'hF, 32'hDEADBEEF})
      $display("FAIL wr_mbus: got %h exp %h",
               {m_adr_o, m_sel_o, m_dat_o},
               {32'h100, 4'hF, 32'hDEADBEEF});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({m_stb_o, m_adr_o, m_dat_o} !==
        {1'b1, 32'h100, 32'hDEADBEEF})
      $display("FAIL wr_hold: got %h exp %h",
               {m_stb_o, m_adr_o, m_dat_o},
               {1'b1, 32'h100, 32'hDEADBEEF});
    else pass_cnt++;
    mack_pulse();
    total_cnt++;
    if ({m_stb_o, m_cyc_o, m_we_o} !== 3'b000)
      $display("FAIL wr_done: got %b exp 000",
               {m_stb_o, m_cyc_o, m_we_o});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic stalled_ack;
    for (int k = 1; k <= 5; k++) begin
      drive_wr(32'h1000 + 32'(4 * k), 4'hF, 32'(k));
      wait_sack(n);
      total_cnt++;
      if (n != 1)
        $display("FAIL b2b_ack%0d: got %0d exp 1", k, n);
      else pass_cnt++;
      idle_bus();
      @(negedge clk);
    end
    // w1 in flight, w2..w5 fill the queue; w6 must stall
    drive_wr(32'h1018, 4'hF, 32'd6);
    stalled_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      stalled_ack |= s_ack_o;
    end
    total_cnt++;
    if (stalled_ack !== 1'b0)
      $display("FAIL b2b_full: got ack %b exp 0",
               stalled_ack);
    else pass_cnt++;
    total_cnt++;
    if ({m_stb_o, m_adr_o} !== {1'b1, 32'h1004})
      $display("FAIL b2b_head: got %h exp %h",
               {m_stb_o, m_adr_o}, {1'b1, 32'h1004});
    else pass_cnt++;
    mack_pulse();
    total_cnt++;
    if ({s_ack_o, m_stb_o} !== 2'b00)
      $display("FAIL b2b_gap: got %b exp 00",
               {s_ack_o, m_stb_o});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({s_ack_o, m_stb_o, m_adr_o} !==
        {2'b01, 32'h1008})
      $display("FAIL b2b_popblk: got %h exp %h",
               {s_ack_o, m_stb_o, m_adr_o},
               {2'b01, 32'h1008});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (s_ack_o !== 1'b1)
      $display("FAIL b2b_late_ack: got %b exp 1", s_ack_o);
    else pass_cnt++;
    idle_bus();
    for (int k = 2; k <= 6; k++) begin
      wait_mstb(n);
      total_cnt++;
      if (n < 0 || {m_we_o, m_adr_o, m_dat_o} !==
          {1'b1, 32'h1000 + 32'(4 * k), 32'(k)})
        $display("FAIL b2b_order%0d: got %h exp %h", k,
                 {m_we_o, m_adr_o, m_dat_o},
                 {1'b1, 32'h1000 + 32'(4 * k), 32'(k)});
      else pass_cnt++;
      mack_pulse();
    end
    repeat (3) @(negedge clk);
    total_cnt++;
    if (m_stb_o !== 1'b0)
      $display("FAIL b2b_drained: got %b exp 0", m_stb_o);
    else pass_cnt++;
  endtask

  task automatic test_raw();
    int n;
    logic rd_early;
    drive_wr(32'h200, 4'hF, 32'h11223344);
    wait_sack(n);
    total_cnt++;
    if (n != 1)
      $display("FAIL raw_wack: got %0d exp 1", n);
    else pass_cnt++;
    drive_rd(32'h200, 4'hF);
    rd_early = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (!(m_stb_o && m_we_o)) rd_early = 1'b1;
    end
    total_cnt++;
    if (rd_early !== 1'b0)
      $display("FAIL raw_block: got %b exp 0", rd_early);
    else pass_cnt++;
    mack_pulse();
    @(negedge clk);
    total_cnt++;
    if ({s_ack_o, m_stb_o, m_we_o, m_adr_o} !==
        {3'b010, 32'h200})
      $display("FAIL raw_rd: got %h exp %h",
               {s_ack_o, m_stb_o, m_we_o, m_adr_o},
               {3'b010, 32'h200});
    else pass_cnt++;
    m_dat_i = 32'hCAFEF00D;
    mack_pulse();
    m_dat_i = '0;
    total_cnt++;
    if ({s_ack_o, m_stb_o, s_dat_o} !==
        {2'b10, 32'hCAFEF00D})
      $display("FAIL raw_rdata: got %h exp %h",
               {s_ack_o, m_stb_o, s_dat_o},
               {2'b10, 32'hCAFEF00D});
    else pass_cnt++;
    idle_bus();
    @(negedge clk);
    total_cnt++;
    if ({s_ack_o, s_dat_o} !== {1'b0, 32'hCAFEF00D})
      $display("FAIL raw_pulse: got %h exp %h",
               {s_ack_o, s_dat_o}, {1'b0, 32'hCAFEF00D});
    else pass_cnt++;
  endtask

  task automatic test_read_latency();
    logic early;
    drive_rd(32'h300, 4'b0011);
    @(negedge clk);
    total_cnt++;
    if ({m_stb_o, m_we_o, m_sel_o, m_adr_o} !==
        {2'b10, 4'b0011, 32'h300})
      $display("FAIL rd_issue: got %h exp %h",
               {m_stb_o, m_we_o, m_sel_o, m_adr_o},
               {2'b10, 4'b0011, 32'h300});
    else pass_cnt++;
    early = 1'b0;
    repeat (3) begin
      @(negedge clk);
      early |= s_ack_o | ~m_stb_o;
    end
    total_cnt++;
    if (early !== 1'b0)
      $display("FAIL rd_wait: got %b exp 0", early);
    else pass_cnt++;
    m_dat_i = 32'h5A5A0F0F;
    mack_pulse();
    m_dat_i = '0;
    total_cnt++;
    if ({s_ack_o, s_dat_o} !== {1'b1, 32'h5A5A0F0F})
      $display("FAIL rd_ret: got %h exp %h",
               {s_ack_o, s_dat_o}, {1'b1, 32'h5A5A0F0F});
    else pass_cnt++;
    idle_bus();
    @(negedge clk);
    total_cnt++;
    if ({s_ack_o, m_stb_o} !== 2'b00)
      $display("FAIL rd_end: got %b exp 00",
               {s_ack_o, m_stb_o});
    else pass_cnt++;
  endtask

  task automatic test_byte_sel();
    int n;
    drive_wr(32'h400, 4'b0100, 32'hA5A5A5A5);
    wait_sack(n);
    idle_bus();
    wait_mstb(n);
    total_cnt++;
    if (n < 0 || {m_sel_o, m_dat_o, m_adr_o} !==
        {4'b0100, 32'hA5A5A5A5, 32'h400})
      $display("FAIL sel_0100: got %h exp %h",
               {m_sel_o, m_dat_o, m_adr_o},
               {4'b0100, 32'hA5A5A5A5, 32'h400});
    else pass_cnt++;
    mack_pulse();
    drive_wr(32'h404, 4'b0000, 32'h0BADF00D);
    wait_sack(n);
    total_cnt++;
    if (n != 1)
      $display("FAIL sel0_ack: got %0d exp 1", n);
    else pass_cnt++;
    idle_bus();
    wait_mstb(n);
    total_cnt++;
    if (n < 0 || {m_sel_o, m_dat_o, m_adr_o} !==
        {4'b0000, 32'h0BADF00D, 32'h404})
      $display("FAIL sel_0000: got %h exp %h",
               {m_sel_o, m_dat_o, m_adr_o},
               {4'b0000, 32'h0BADF00D, 32'h404});
    else pass_cnt++;
    mack_pulse();
  endtask

  task automatic test_reset_mid();
    int n;
    logic stray;
    for (int k = 0; k < 4; k++) begin
      drive_wr(32'h500 + 32'(4 * k), 4'hF, 32'(k));
      wait_sack(n);
      idle_bus();
      @(negedge clk);
    end
    total_cnt++;
    if ({m_stb_o, m_adr_o} !== {1'b1, 32'h500})
      $display("FAIL rmid_pre: got %h exp %h",
               {m_stb_o, m_adr_o}, {1'b1, 32'h500});
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({m_stb_o, m_cyc_o, s_ack_o} !== 3'b000)
      $display("FAIL rmid_drop: got %b exp 000",
               {m_stb_o, m_cyc_o, s_ack_o});
    else pass_cnt++;
    reset = 1'b0;
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      stray |= m_stb_o | m_cyc_o | s_ack_o;
    end
    total_cnt++;
    if ({stray, m_adr_o} !== 33'd0)
      $display("FAIL rmid_quiet: got %h exp 0",
               {stray, m_adr_o});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_raw();
    test_read_latency();
    test_byte_sel();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
